inter_core_fifo: RTL

INTER_CORE_FIFO -- requirements
Module: inter_core_fifo

---
 rtl/inter_core_fifo_pkg.sv | 13 +
 rtl/inter_core_fifo_store.sv | 57 +++++
 rtl/inter_core_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/inter_core_fifo_pkg.sv
// Shared constants for the inter-core FIFO: register offsets (address bits [3:2])
// and response opcodes.
package inter_core_fifo_pkg;

  typedef enum logic [1:0] {
    OFF_DATA   = 2'd0,
    OFF_STATUS = 2'd1
  } offset_e;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

endpackage

// File: rtl/inter_core_fifo_store.sv
// Circular word storage with head/tail pointers and an occupancy count.
// The caller guarantees no push while full (unless popping) and no pop while empty.
module inter_core_fifo_store #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [31:0]   wdata_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic [31:0]   head_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    head_d  = pop_i  ? head_q + 1'b1 : head_q;
    tail_d  = push_i ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Data array carries no reset; the head is only consumed when count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[tail_q] <= wdata_i;
  end

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[head_q];

endmodule

// File: rtl/inter_core_fifo.sv
// Inter-core mailbox FIFO with a push port (upstream core) and a pop port (local core).
// Define INTER_CORE_FIFO_STATUS_EN to expose the status word at pop-port offset 0x4.
module inter_core_fifo
  import inter_core_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int ID_WIDTH   = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                psh_req_i,
  input  logic [31:0]         psh_add_i,
  input  logic                psh_wen_i,
  input  logic [31:0]         psh_wdata_i,
  input  logic [3:0]          psh_be_i,
  input  logic [ID_WIDTH-1:0] psh_id_i,
  output logic                psh_gnt_o,
  output logic                psh_r_valid_o,
  output logic                psh_r_opc_o,
  output logic [ID_WIDTH-1:0] psh_r_id_o,
  output logic [31:0]         psh_r_rdata_o,
  input  logic                pop_req_i,
  input  logic [31:0]         pop_add_i,
  input  logic                pop_wen_i,
  input  logic [31:0]         pop_wdata_i,
  input  logic [3:0]          pop_be_i,
  input  logic [ID_WIDTH-1:0] pop_id_i,
  output logic                pop_gnt_o,
  output logic                pop_r_valid_o,
  output logic                pop_r_opc_o,
  output logic [ID_WIDTH-1:0] pop_r_id_o,
  output logic [31:0]         pop_r_rdata_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          full, empty;
  logic [AW:0]   count;
  logic [31:0]   head;
  logic          psh_is_data, pop_is_data, push_do, pop_do;
  logic          pop_opc_d;
  logic [31:0]   pop_rdata_d;

  logic                psh_vld_q, psh_opc_q, pop_vld_q, pop_opc_q;
  logic [ID_WIDTH-1:0] psh_id_q, pop_id_q;
  logic [31:0]         psh_rdata_q, pop_rdata_q;

  assign psh_is_data = !psh_wen_i && (psh_add_i[3:2] == OFF_DATA);
  assign pop_is_data =  pop_wen_i && (pop_add_i[3:2] == OFF_DATA);

  // A same-cycle pop frees the slot the push needs, so a full FIFO still accepts it.
  assign pop_do    = pop_req_i && pop_is_data && !empty && !rst_i;
  assign pop_gnt_o = pop_req_i && !rst_i;
  assign psh_gnt_o = psh_req_i && !rst_i && (!psh_is_data || !full || pop_do);
  assign push_do   = psh_gnt_o && psh_is_data;

  inter_core_fifo_store #(.DEPTH(FIFO_DEPTH)) u_store (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_do),
    .wdata_i (psh_wdata_i),
    .pop_i   (pop_do),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  always_comb begin
    pop_opc_d   = OPC_ERR;
    pop_rdata_d = '0;
    if (pop_do) begin
      pop_opc_d   = OPC_OK;
      pop_rdata_d = head;
    end
`ifdef INTER_CORE_FIFO_STATUS_EN
    else if (pop_wen_i && (pop_add_i[3:2] == OFF_STATUS)) begin
      pop_opc_d   = OPC_OK;
      pop_rdata_d = {full, empty, 14'b0, 16'(count)};
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psh_vld_q   <= 1'b0;
      psh_opc_q   <= OPC_OK;
      psh_id_q    <= '0;
      psh_rdata_q <= '0;
      pop_vld_q   <= 1'b0;
      pop_opc_q   <= OPC_OK;
      pop_id_q    <= '0;
      pop_rdata_q <= '0;
    end else begin
      psh_vld_q   <= psh_gnt_o;
      psh_opc_q   <= psh_gnt_o ? (psh_is_data ? OPC_OK : OPC_ERR) : OPC_OK;
      psh_id_q    <= psh_gnt_o ? psh_id_i : '0;
      psh_rdata_q <= '0;
      pop_vld_q   <= pop_gnt_o;
      pop_opc_q   <= pop_gnt_o ? pop_opc_d : OPC_OK;
      pop_id_q    <= pop_gnt_o ? pop_id_i : '0;
      pop_rdata_q <= pop_gnt_o ? pop_rdata_d : '0;
    end
  end

  assign psh_r_valid_o = psh_vld_q;
  assign psh_r_opc_o   = psh_opc_q;
  assign psh_r_id_o    = psh_id_q;
  assign psh_r_rdata_o = psh_rdata_q;
  assign pop_r_valid_o = pop_vld_q;
  assign pop_r_opc_o   = pop_opc_q;
  assign pop_r_id_o    = pop_id_q;
  assign pop_r_rdata_o = pop_rdata_q;

  logic unused_ok;
  assign unused_ok = ^{psh_add_i[31:4], psh_add_i[1:0], pop_add_i[31:4], pop_add_i[1:0],
                       psh_be_i, pop_be_i, pop_wdata_i, count};

endmodule
